uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter among NUM_REQ independent requesters.
- Arbitration is round-robin with packet lock. A granted requester keeps the transmitter until it sends a byte flagged last.
- Each byte is sequenced through the transmitter's start/busy handshake. A watchdog recovers if the transmitter never goes busy.
- Sits between the command/response sources and the single uart_tx instance on the serial link.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 64, clk cycles to wait for tx_busy to rise after tx_start before aborting.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is final byte of its packet.
- req_ready  output  NUM_REQ  byte accepted this cycle (combinational).
- tx_start  output  1  one-cycle pulse to uart_tx.
- tx_data  output  8  byte to uart_tx, valid while tx_start is high and held afterwards.
- tx_busy  input  1  uart_tx frame in progress.
- grant  output  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- timeout_err  output  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0.
  - tx_start=0, tx_data=8'h00, timeout_err=0.
  - last_q=0, timer=0.
  - req_ready=0 (decoded from state).
- Reset mid-operation aborts immediately. No tx_start is issued after reset. Any in-flight uart_tx frame is not tracked.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is high: pick winner g as the first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register grant=onehot(g) and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - req_ready[g] = req_valid[g]. All other req_ready bits are 0.
  - On acceptance (req_valid[g]=1):
    - Next cycle tx_start=1 for exactly one cycle.
    - tx_data = req_data[g] and last_q = req_last[g], captured on the accepting cycle.
    - timer=0, go to WAIT_BUSY.
  - If req_valid[g]=0, stay in LOAD holding grant (packet lock). Other requesters are never served meanwhile.
- WAIT_BUSY:
  - timer increments each cycle.
  - If tx_busy=1, go to WAIT_DONE.
  - Else if timer reaches BUSY_TIMEOUT-1:
    - timeout_err pulses one cycle.
    - grant=0, rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
    - The remaining bytes of that packet are abandoned; the requester must restart the packet.
  - tx_busy high on the same cycle as the timeout terminal count wins: go to WAIT_DONE, no error.
- WAIT_DONE:
  - Wait for tx_busy=0.
  - If last_q=1: grant=0, rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
  - Else go to LOAD with the same grant.
- Latency:
  - req_valid rising in IDLE: grant one cycle later, req_ready the same cycle as grant, tx_start the cycle after acceptance.
  - After a frame, tx_busy falling leads to the next req_ready no earlier than 1 cycle later (same requester) or 2 cycles later (new requester, via IDLE).
- Simultaneous requests: exactly one winner. The winner of the next packet is the next valid index after the previous owner (wrap-around from NUM_REQ-1 to 0).
- req_data and req_last of non-granted requesters are ignored. Requesters must hold valid, data and last until ready.
- At most one accepted byte per uart_tx frame; tx_start is never asserted while in WAIT_BUSY or WAIT_DONE.
- grant is stable for the whole packet and always one-hot or zero.

Test Plan:
- Single requester 0 sends 3 bytes 8'hA1, 8'hA2, 8'hA3 (last on A3); model uart_tx with busy=1 for 10 cycles starting 1 cycle after tx_start → three tx_start pulses carrying A1, A2, A3 in order; grant=0001 throughout; returns to IDLE with grant=0.
- Requesters 0..3 all valid with 1-byte packets (data 8'h10+i), held continuously → service order 0,1,2,3,0; exactly one req_ready high per accepted byte.
- Requester 1 sends a 2-byte packet but drops valid for 20 cycles between bytes while requester 2 is valid → requester 2 is never granted until requester 1's last byte completes.
- tx_busy held at 0 after tx_start, BUSY_TIMEOUT=64 → timeout_err pulses exactly 64 cycles after entering WAIT_BUSY; grant→0; next packet goes to the next index.
- rst asserted during WAIT_DONE of a multi-byte packet → next cycle all outputs at reset values; after release, arbitration restarts from index 0.
- rr_ptr wrap: owner 3 finishes while requesters 0 and 2 are valid → requester 0 is granted.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester and uart_tx handshake bundle for uart_tx_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [NUM_REQ-1:0]   grant;
    logic                 timeout_err;

    // The arbiter is the slave of the requesters and drives the transmitter.
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_start, tx_data, grant, timeout_err
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_start, tx_data, grant, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-locked sharing of one uart_tx transmitter.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [TMR_W-1:0] c_timer_term = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   c_num_req    = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [IDX_W-1:0]   rr_q;
    logic               tx_start_q;
    logic [7:0]         tx_data_q;
    logic               timeout_q;
    logic               last_q;
    logic [TMR_W-1:0]   timer_q;

    logic [IDX_W-1:0]   w_win_idx;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic               w_found;
    logic [IDX_W:0]     w_scan;
    logic               w_sel_valid;
    logic [7:0]         w_sel_data;
    logic               w_sel_last;
    logic               w_accept;
    logic [IDX_W-1:0]   w_next_rr;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        w_win_idx = '0;
        w_found   = 1'b0;
        w_scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, rr_q} + (IDX_W + 1)'(k);
            if (w_scan >= c_num_req) begin
                w_scan = w_scan - c_num_req;
            end
            if (!w_found && bus.req_valid[w_scan[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_scan[IDX_W-1:0];
            end
        end
    end

    assign w_win_onehot = NUM_REQ'(1) << w_win_idx;
    assign w_sel_valid  = bus.req_valid[gidx_q];
    assign w_sel_data   = bus.req_data[{gidx_q, 3'b000} +: 8];
    assign w_sel_last   = bus.req_last[gidx_q];
    assign w_accept     = (state_q == S_LOAD) && w_sel_valid;
    assign w_next_rr    = (gidx_q == c_last_idx) ? '0 : gidx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_q       <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            timeout_q  <= 1'b0;
            last_q     <= 1'b0;
            timer_q    <= '0;
        end else begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        grant_q <= w_win_onehot;
                        gidx_q  <= w_win_idx;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Grant is held even while the owner has nothing to send.
                    if (w_accept) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= w_sel_data;
                        last_q     <= w_sel_last;
                        timer_q    <= '0;
                        state_q    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    timer_q <= timer_q + 1'b1;
                    if (bus.tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (timer_q == c_timer_term) begin
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                        rr_q      <= w_next_rr;
                        state_q   <= S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            grant_q <= '0;
                            rr_q    <= w_next_rr;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready   = (state_q == S_LOAD) ? (grant_q & bus.req_valid) : '0;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed scenario bench for uart_tx_arbiter with a uart_tx model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

    uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // uart_tx model: busy for 10 cycles starting one cycle after tx_start.
    int   busy_cnt = 0;
    logic uart_en  = 1'b1;
    always @(posedge clk) begin
        if (rst)                         busy_cnt <= 0;
        else if (bus.tx_start && uart_en) busy_cnt <= 10;
        else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    int total = 0;
    int bad   = 0;

    logic [7:0] pd [NR][8];
    logic       pl [NR][8];
    int         pg [NR][8];
    int         pn [NR];
    int         pp [NR];
    int         gc [NR];
    logic [NR-1:0] acc;
    int cyc = 0;
    int viol;

    int         acc_idx[$];
    logic [7:0] acc_dat[$];
    logic [7:0] tx_dat[$];
    logic [3:0] tx_gnt[$];
    logic [3:0] gseq[$];
    int         t_start[$];
    int         t_to[$];
    int         t_valid_first, t_grant_first;
    logic [3:0] last_grant;

    task automatic clear_prog();
        for (int r = 0; r < NR; r++) begin
            pn[r] = 0; pp[r] = 0; gc[r] = 0;
        end
        acc = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
    endtask

    task automatic clear_logs();
        acc_idx.delete(); acc_dat.delete(); tx_dat.delete(); tx_gnt.delete();
        gseq.delete(); t_start.delete(); t_to.delete();
        t_valid_first = -1; t_grant_first = -1; last_grant = '0; viol = 0;
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic l, input int g);
        pd[r][pn[r]] = d; pl[r][pn[r]] = l; pg[r][pn[r]] = g;
        if (pn[r] == 0) gc[r] = g;
        pn[r]++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        uart_en = 1'b1;
        clear_prog();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    // One clock of requester driving, then observation mid-cycle.
    task automatic step();
        @(negedge clk);
        for (int r = 0; r < NR; r++) begin
            if (acc[r]) begin
                pp[r]++;
                if (pp[r] < pn[r]) gc[r] = pg[r][pp[r]];
            end
            if (pp[r] < pn[r] && gc[r] == 0) begin
                bus.req_valid[r]      = 1'b1;
                bus.req_data[8*r +: 8] = pd[r][pp[r]];
                bus.req_last[r]       = pl[r][pp[r]];
            end else begin
                bus.req_valid[r] = 1'b0;
                if (pp[r] < pn[r]) gc[r]--;
            end
        end
        #1;
        cyc++;
        acc = bus.req_valid & bus.req_ready;
        for (int r = 0; r < NR; r++) begin
            if (acc[r]) begin
                acc_idx.push_back(r);
                acc_dat.push_back(pd[r][pp[r]]);
            end
        end
        if (acc != '0 && !$onehot(acc)) viol++;
        if ((bus.req_ready & ~bus.grant) != '0) viol++;
        if (!$onehot0(bus.grant)) viol++;
        if (t_valid_first < 0 && bus.req_valid != '0) t_valid_first = cyc;
        if (t_grant_first < 0 && bus.grant != '0) t_grant_first = cyc;
        if (bus.tx_start) begin
            tx_dat.push_back(bus.tx_data);
            tx_gnt.push_back(bus.grant);
            t_start.push_back(cyc);
        end
        if (bus.timeout_err) t_to.push_back(cyc);
        if (bus.grant !== last_grant) begin
            gseq.push_back(bus.grant);
            last_grant = bus.grant;
        end
    endtask

    task automatic run_idle(input string name, input int budget);
        int  n;
        bit  done;
        n = 0;
        do begin
            step();
            n++;
            done = (bus.grant == '0) && !bus.tx_busy && (acc == '0);
            for (int r = 0; r < NR; r++) if (pp[r] < pn[r]) done = 1'b0;
        end while (!done && n < budget);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: not idle after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1; bus.req_last = '1; bus.req_data = '1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", bus.grant); end
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%b want=0", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h want=00", bus.tx_data); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", bus.timeout_err); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b want=0000", bus.req_ready); end
        clear_prog();
    endtask

    task automatic test_single();
        logic [7:0] ed [3] = '{8'hA1, 8'hA2, 8'hA3};
        do_reset();
        add_byte(0, 8'hA1, 1'b0, 0);
        add_byte(0, 8'hA2, 1'b0, 0);
        add_byte(0, 8'hA3, 1'b1, 0);
        run_idle("single_run", 300);
        total++; if (tx_dat.size() != 3) begin bad++; $display("FAIL single_count got=%0d want=3", tx_dat.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (tx_dat[i] !== ed[i]) begin bad++; $display("FAIL single_data[%0d] got=%h want=%h", i, tx_dat[i], ed[i]); end
            total++; if (tx_gnt[i] !== 4'b0001) begin bad++; $display("FAIL single_grant[%0d] got=%b want=0001", i, tx_gnt[i]); end
        end
        total++; if (gseq.size() != 2 || gseq[0] !== 4'b0001 || gseq[1] !== 4'b0000) begin
            bad++; $display("FAIL single_gseq got size=%0d first=%b want 0001,0000", gseq.size(), gseq[0]); end
        total++; if (t_grant_first - t_valid_first != 1) begin bad++; $display("FAIL single_grant_lat got=%0d want=1", t_grant_first - t_valid_first); end
        total++; if (t_start[0] - t_valid_first != 2) begin bad++; $display("FAIL single_start_lat got=%0d want=2", t_start[0] - t_valid_first); end
        total++; if (viol != 0) begin bad++; $display("FAIL single_onehot got=%0d want=0", viol); end
    endtask

    task automatic test_all4();
        int         ei [5] = '{0, 1, 2, 3, 0};
        logic [7:0] ed [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        add_byte(0, 8'h10, 1'b1, 0);
        add_byte(0, 8'h10, 1'b1, 0);
        for (int r = 1; r < NR; r++) add_byte(r, 8'h10 + 8'(r), 1'b1, 0);
        run_idle("all4_run", 400);
        total++; if (acc_idx.size() != 5) begin bad++; $display("FAIL all4_count got=%0d want=5", acc_idx.size()); end
        for (int i = 0; i < 5; i++) begin
            total++; if (acc_idx[i] != ei[i]) begin bad++; $display("FAIL all4_order[%0d] got=%0d want=%0d", i, acc_idx[i], ei[i]); end
            total++; if (tx_dat[i] !== ed[i]) begin bad++; $display("FAIL all4_data[%0d] got=%h want=%h", i, tx_dat[i], ed[i]); end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL all4_onehot got=%0d want=0", viol); end
    endtask

    task automatic test_lock();
        logic [7:0] ed [3] = '{8'h21, 8'h22, 8'h31};
        logic [3:0] eg [4] = '{4'b0010, 4'b0000, 4'b0100, 4'b0000};
        do_reset();
        add_byte(1, 8'h21, 1'b0, 0);
        add_byte(1, 8'h22, 1'b1, 20);
        add_byte(2, 8'h31, 1'b1, 0);
        run_idle("lock_run", 400);
        total++; if (tx_dat.size() != 3) begin bad++; $display("FAIL lock_count got=%0d want=3", tx_dat.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (tx_dat[i] !== ed[i]) begin bad++; $display("FAIL lock_data[%0d] got=%h want=%h", i, tx_dat[i], ed[i]); end
        end
        total++; if (gseq.size() != 4) begin bad++; $display("FAIL lock_gseq_len got=%0d want=4", gseq.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (gseq[i] !== eg[i]) begin bad++; $display("FAIL lock_gseq[%0d] got=%b want=%b", i, gseq[i], eg[i]); end
        end
        total++; if (t_start[1] - t_start[0] != 21) begin bad++; $display("FAIL lock_gap got=%0d want=21", t_start[1] - t_start[0]); end
    endtask

    task automatic test_timeout();
        logic [7:0] ed [3] = '{8'h55, 8'h66, 8'h56};
        logic [3:0] eg [3] = '{4'b0001, 4'b0010, 4'b0001};
        logic [3:0] g_at_to;
        int n;
        do_reset();
        uart_en = 1'b0;
        add_byte(0, 8'h55, 1'b0, 0);
        add_byte(0, 8'h56, 1'b1, 0);
        add_byte(1, 8'h66, 1'b1, 0);
        n = 0;
        g_at_to = 4'hF;
        while (t_to.size() == 0 && n < 200) begin
            step();
            n++;
        end
        g_at_to = bus.grant;
        total++; if (t_to.size() != 1) begin bad++; $display("FAIL to_seen got=%0d want=1", t_to.size()); end
        uart_en = 1'b1;
        run_idle("to_run", 400);
        total++; if (t_to.size() != 1) begin bad++; $display("FAIL to_pulses got=%0d want=1", t_to.size()); end
        total++; if (t_to[0] - t_start[0] != 64) begin bad++; $display("FAIL to_delay got=%0d want=64", t_to[0] - t_start[0]); end
        total++; if (g_at_to !== 4'b0000) begin bad++; $display("FAIL to_grant got=%b want=0000", g_at_to); end
        total++; if (tx_dat.size() != 3) begin bad++; $display("FAIL to_count got=%0d want=3", tx_dat.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (tx_dat[i] !== ed[i] || tx_gnt[i] !== eg[i]) begin
                bad++; $display("FAIL to_tx[%0d] got=%h/%b want=%h/%b", i, tx_dat[i], tx_gnt[i], ed[i], eg[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        add_byte(1, 8'h41, 1'b1, 0);
        add_byte(2, 8'h51, 1'b0, 0);
        add_byte(2, 8'h52, 1'b0, 0);
        add_byte(2, 8'h53, 1'b1, 0);
        n = 0;
        while (tx_dat.size() < 2 && n < 200) begin
            step();
            n++;
        end
        repeat (5) step();
        total++; if (bus.grant !== 4'b0100 || !bus.tx_busy) begin
            bad++; $display("FAIL mid_pre got grant=%b busy=%b want 0100/1", bus.grant, bus.tx_busy); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL mid_grant got=%b want=0000", bus.grant); end
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL mid_tx_start got=%b want=0", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL mid_tx_data got=%h want=00", bus.tx_data); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL mid_timeout got=%b want=0", bus.timeout_err); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready got=%b want=0000", bus.req_ready); end
        clear_prog();
        rst = 1'b0;
        clear_logs();
        repeat (4) step();
        total++; if (tx_dat.size() != 0) begin bad++; $display("FAIL mid_no_start got=%0d want=0", tx_dat.size()); end
        add_byte(1, 8'h81, 1'b1, 0);
        add_byte(3, 8'h83, 1'b1, 0);
        run_idle("mid_run", 300);
        total++; if (tx_dat.size() != 2 || tx_dat[0] !== 8'h81 || tx_gnt[0] !== 4'b0010) begin
            bad++; $display("FAIL mid_restart got=%h/%b want=81/0010", tx_dat[0], tx_gnt[0]); end
        total++; if (tx_dat[1] !== 8'h83 || tx_gnt[1] !== 4'b1000) begin
            bad++; $display("FAIL mid_second got=%h/%b want=83/1000", tx_dat[1], tx_gnt[1]); end
    endtask

    task automatic test_wrap();
        logic [7:0] ed [4] = '{8'h93, 8'h94, 8'hA0, 8'hA2};
        logic [3:0] eg [4] = '{4'b1000, 4'b1000, 4'b0001, 4'b0100};
        do_reset();
        add_byte(3, 8'h93, 1'b0, 0);
        add_byte(3, 8'h94, 1'b1, 0);
        add_byte(0, 8'hA0, 1'b1, 3);
        add_byte(2, 8'hA2, 1'b1, 3);
        run_idle("wrap_run", 400);
        total++; if (tx_dat.size() != 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", tx_dat.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (tx_dat[i] !== ed[i] || tx_gnt[i] !== eg[i]) begin
                bad++; $display("FAIL wrap_tx[%0d] got=%h/%b want=%h/%b", i, tx_dat[i], tx_gnt[i], ed[i], eg[i]); end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL wrap_onehot got=%0d want=0", viol); end
    endtask

    initial begin
        clear_prog();
        clear_logs();
        test_reset();
        test_single();
        test_all4();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1, "global timeout");
    end
endmodule
`default_nettype wire
